// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions and hex glyph table.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}; digits A-F use the A,b,C,d,E,F shapes.
// Pure constants, no logic, no latency.
package seg_scan_driver_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;
  localparam logic [6:0] GLYPH_OFF   = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low 7-segment glyph {g,f,e,d,c,b,a}.
// Combinational, zero latency.
// No handshake; output follows input.
module seg_hex_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: one digit per DIV-cycle slot, PWM brightness, leading-zero blanking.
// AN/SEG/ce1ms are registered, one cycle behind the cnt/idx state.
// No backpressure; inputs are captured into shadows at frame start so a frame is always self-consistent.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] dat,
  input  logic [NDIG-1:0]   dp,
  input  logic              blank_lz,
  input  logic [2:0]        bright,
  output logic [NDIG-1:0]   AN,
  output logic [7:0]        SEG,
  output logic              ce1ms
);

  localparam int CW      = $clog2(DIV);
  localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ON_STEP = DIV / 8;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] dat_sh;
  logic [NDIG-1:0]   dp_sh;
  logic              blz_sh;
  logic [2:0]        bright_sh;
  logic              first;      // first cycle after reset: shadows are stale, use inputs directly

  logic              slot_end;
  logic              frame_end;
  logic [4*NDIG-1:0] dat_use;
  logic [NDIG-1:0]   dp_use;
  logic              blz_use;
  logic [2:0]        bright_use;
  logic [3:0]        nib;
  logic              dp_cur;
  logic              lz_run;
  logic              lz_cur;
  logic              blank;
  logic [6:0]        glyph;
  logic [31:0]       on_lim;
  logic              lit;
  logic [NDIG-1:0]   an_nxt;
  logic [7:0]        seg_nxt;

  assign slot_end  = (cnt == CW'(DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NDIG - 1));

  assign dat_use    = first ? dat      : dat_sh;
  assign dp_use     = first ? dp       : dp_sh;
  assign blz_use    = first ? blank_lz : blz_sh;
  assign bright_use = first ? bright   : bright_sh;

  // Select the current digit's nibble/dp and find whether it and everything left of it is zero.
  always_comb begin
    nib    = 4'h0;
    dp_cur = 1'b0;
    lz_run = 1'b1;
    lz_cur = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_run = lz_run & (dat_use[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib    = dat_use[4*i +: 4];
        dp_cur = dp_use[i];
        lz_cur = lz_run;
      end
    end
  end

  assign blank = blz_use && (idx != '0) && lz_cur;

  seg_hex_decode u_dec (
    .hex (nib),
    .seg (glyph)
  );

  assign seg_nxt = {~dp_cur, blank ? GLYPH_OFF : glyph};

  // Anode on-window: brightness-scaled prefix of the slot, never the slot's last cycle.
  always_comb begin
    on_lim = (32'(bright_use) + 32'd1) * 32'(ON_STEP);
    lit    = !slot_end && (32'(cnt) < on_lim);
    for (int i = 0; i < NDIG; i++) begin
      an_nxt[i] = !(lit && (idx == IW'(i)));
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Frame shadows load at frame start; brightness reloads at every slot start.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_sh    <= '0;
      dp_sh     <= '0;
      blz_sh    <= 1'b0;
      bright_sh <= 3'd0;
    end else begin
      if (first || frame_end) begin
        dat_sh <= dat;
        dp_sh  <= dp;
        blz_sh <= blank_lz;
      end
      if (first || slot_end) begin
        bright_sh <= bright;
      end
    end
  end

  // Registered outputs; segments are dark whenever no anode is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN    <= '1;
      SEG   <= SEG_ALL_OFF;
      ce1ms <= 1'b0;
    end else begin
      AN    <= an_nxt;
      SEG   <= lit ? seg_nxt : SEG_ALL_OFF;
      ce1ms <= slot_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NDIG=4, DIV=16.
// Table of per-frame vectors plus hand sequences for brightness hold, mid-frame data change and mid-slot reset.
// Outputs sampled 1 time unit after each rising edge.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dat = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        blank_lz = 1'b0;
  logic [2:0]  bright = 3'd0;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic        ce1ms;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(.NDIG(4), .DIV(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .dat      (dat),
    .dp       (dp),
    .blank_lz (blank_lz),
    .bright   (bright),
    .AN       (AN),
    .SEG      (SEG),
    .ce1ms    (ce1ms)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dat;
    logic [3:0]  dp;
    logic        blz;
    logic [2:0]  br;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
    int          on;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Hold reset for two cycles with the given inputs, check reset outputs, then release.
  task automatic do_reset(input logic [15:0] d, input logic [3:0] p, input logic z, input logic [2:0] b);
    rst      = 1'b1;
    dat      = d;
    dp       = p;
    blank_lz = z;
    bright   = b;
    tick();
    tick();
    chk("reset_out", {19'd0, ce1ms, SEG, AN}, {19'd0, 1'b0, 8'hFF, 4'hF});
    rst = 1'b0;
  endtask

  // Observe one 16-cycle slot; optionally change dat/bright after sample chg_at.
  task automatic run_slot(input int ix, input logic [7:0] es, input int on,
                          input int chg_at, input logic [15:0] nd, input logic [2:0] nb,
                          input string tag);
    logic [15:0] litm;
    logic [15:0] cem;
    int          anbad;
    int          segbad;
    logic [3:0]  ean;
    litm   = '0;
    cem    = '0;
    anbad  = 0;
    segbad = 0;
    ean    = ~(4'b0001 << ix);
    for (int j = 0; j < 16; j++) begin
      tick();
      litm[j] = (AN != 4'hF);
      cem[j]  = ce1ms;
      if (AN != 4'hF) begin
        if (AN != ean) anbad++;
        if (SEG != es) segbad++;
      end else if (SEG != 8'hFF) begin
        segbad++;
      end
      if (j == chg_at) begin
        dat    = nd;
        bright = nb;
      end
    end
    chk({tag, "_ontime"}, {16'd0, litm}, (32'd1 << on) - 32'd1);
    chk({tag, "_an_bad"}, anbad, 0);
    chk({tag, "_seg_bad"}, segbad, 0);
    chk({tag, "_ce1ms"}, {16'd0, cem}, 32'h0000_8000);
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, 3'd7, 32'hF9A4_888E, 15};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 3'd3, 32'hFFFF_FF92, 8};
    vecs[2] = '{16'h0005, 4'b0000, 1'b0, 3'd0, 32'hC0C0_C092, 2};
    vecs[3] = '{16'h0105, 4'b0000, 1'b1, 3'd5, 32'hFFF9_C092, 12};
    vecs[4] = '{16'h3456, 4'b0100, 1'b0, 3'd7, 32'hB019_9282, 15};
    vecs[5] = '{16'h0000, 4'b0010, 1'b1, 3'd1, 32'hFFFF_7FC0, 4};
    vecs[6] = '{16'h789E, 4'b1001, 1'b0, 3'd6, 32'h7880_9006, 14};
    vecs[7] = '{16'hDCB0, 4'b0000, 1'b1, 3'd2, 32'hA1C6_83C0, 6};

    // Table: each vector gets a fresh reset and two full frames.
    for (int v = 0; v < 8; v++) begin
      do_reset(vecs[v].dat, vecs[v].dp, vecs[v].blz, vecs[v].br);
      for (int f = 0; f < 2; f++) begin
        for (int d = 0; d < 4; d++) begin
          logic [31:0] sv;
          sv = vecs[v].segs;
          run_slot(d, sv[8*d +: 8], vecs[v].on, -1, vecs[v].dat, vecs[v].br,
                   $sformatf("vec%0d_f%0d_d%0d", v, f, d));
        end
      end
    end

    // Brightness changed mid-slot takes effect only from the next slot.
    do_reset(16'h1111, 4'h0, 1'b0, 3'd7);
    run_slot(0, 8'hF9, 15, 4, 16'h1111, 3'd0, "bright_hold_s0");
    run_slot(1, 8'hF9, 2, -1, 16'h1111, 3'd0, "bright_hold_s1");
    run_slot(2, 8'hF9, 2, -1, 16'h1111, 3'd0, "bright_hold_s2");

    // Data changed while idx=2: rest of frame keeps old data, next frame shows new.
    do_reset(16'h1111, 4'h0, 1'b0, 3'd7);
    run_slot(0, 8'hF9, 15, -1, 16'h1111, 3'd7, "midframe_d0");
    run_slot(1, 8'hF9, 15, -1, 16'h1111, 3'd7, "midframe_d1");
    dat = 16'h2222;
    run_slot(2, 8'hF9, 15, -1, 16'h2222, 3'd7, "midframe_d2");
    run_slot(3, 8'hF9, 15, -1, 16'h2222, 3'd7, "midframe_d3");
    for (int d = 0; d < 4; d++) begin
      run_slot(d, 8'hA4, 15, -1, 16'h2222, 3'd7, $sformatf("newframe_d%0d", d));
    end

    // One-cycle reset at cnt=9, idx=2 aborts the slot and restarts at digit 0.
    do_reset(16'h12AF, 4'h0, 1'b0, 3'd7);
    run_slot(0, 8'h8E, 15, -1, 16'h12AF, 3'd7, "pre_rst_d0");
    run_slot(1, 8'h88, 15, -1, 16'h12AF, 3'd7, "pre_rst_d1");
    for (int j = 0; j < 9; j++) tick();
    rst = 1'b1;
    tick();
    chk("midslot_rst_out", {19'd0, ce1ms, SEG, AN}, {19'd0, 1'b0, 8'hFF, 4'hF});
    rst = 1'b0;
    run_slot(0, 8'h8E, 15, -1, 16'h12AF, 3'd7, "post_rst_d0");
    run_slot(1, 8'h88, 15, -1, 16'h12AF, 3'd7, "post_rst_d1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed 7-segment digits, range 1..8.
REQ-002 Parameter DIV, default 50000: clk cycles per digit slot (1 ms at 50 MHz); minimum 16, multiple of 8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 dat  input  4*NDIG  hex nibbles; nibble i = dat[4i+3:4i] drives digit i (digit 0 rightmost).
REQ-006 dp  input  NDIG  per-digit decimal point request, 1 = lit.
REQ-007 blank_lz  input  1  1 = blank leading-zero digits.
REQ-008 bright  input  3  brightness level 0..7.
REQ-009 AN  output  NDIG  digit anode enables, active-low, at most one low at any time.
REQ-010 SEG  output  8  segments {dp,g,f,e,d,c,b,a} = SEG[7:0], active-low.
REQ-011 ce1ms  output  1  one-cycle strobe at each digit-slot boundary.

Function
REQ-012 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0; ce1ms SHALL be 1 in exactly the cycle after cnt equals DIV-1.
REQ-013 Digit index idx SHALL advance by one on each slot wrap and wrap from NDIG-1 to 0.
REQ-014 Shadow registers for dat, dp and blank_lz SHALL load only when idx wraps to 0 (frame start); mid-frame input changes SHALL NOT affect the current frame.
REQ-015 Hex decode SHALL cover 0-9 and A-F (A,b,C,d,E,F glyphs); SEG[7] SHALL be 0 when shadow dp[idx] is 1.
REQ-016 With blank_lz=1, digit i>0 SHALL be blanked (SEG=8'hFF except dp) when all shadow nibbles i..NDIG-1 are zero; digit 0 SHALL never be blanked.
REQ-017 Anode AN[idx] SHALL be driven low only while cnt < (bright+1)*(DIV/8); all AN high otherwise.
REQ-018 bright SHALL be sampled at each slot start and held for the whole slot.
REQ-019 AN, SEG and ce1ms SHALL be registered; each output reflects cnt/idx state with exactly one cycle latency.
REQ-020 During each slot's final cycle (cnt=DIV-1) all AN SHALL be high (ghosting guard), regardless of bright.
REQ-021 bright=7 SHALL give on-time DIV-1 cycles per slot; bright=0 SHALL give DIV/8 cycles.

Reset
REQ-022 While rst=1: cnt=0, idx=0, shadows=0, AN all 1, SEG=8'hFF, ce1ms=0.
REQ-023 Reset asserted mid-slot SHALL abort the slot; the first slot after release SHALL be digit 0 with fresh shadow load from inputs in the first post-reset cycle.

Structure
REQ-024 Shared package SHALL hold the 16-entry hex-to-segment constant table and segment bit-position constants.
REQ-025 Hex decode SHALL be a sub-module seg_hex_decode (4-bit in, 7-bit active-low out, combinational), instantiated once.
REQ-026 No clock enables derived as clocks; single BUFG'd clk domain only.

Verification (NDIG=4, DIV=16)
REQ-027 Release rst, dat=16'h12AF, dp=0, bright=7 -> AN cycles 1110,1101,1011,0111 every 16 clk; SEG = 8'h8E,8'h88,8'hA4,8'hF9 for digits 0..3; ce1ms every 16 cycles.
REQ-028 dat=16'h0005, blank_lz=1 -> digits 1-3 SEG=8'hFF, digit 0 SEG=8'h92; with blank_lz=0 digits 1-3 SEG=8'hC0.
REQ-029 bright=0 -> AN low exactly 2 cycles per slot; bright=3 -> 8 cycles; bright=7 -> 15 cycles.
REQ-030 Change dat from 16'h1111 to 16'h2222 while idx=2 -> digits 2,3 still show 1; next frame all show 2.
REQ-031 dp=4'b0100 -> SEG[7]=0 only while AN[2] low.
REQ-032 Assert rst for 1 cycle at cnt=9, idx=2 -> next cycle AN=4'hF, SEG=8'hFF, ce1ms=0; scan restarts at digit 0, ce1ms 16 cycles after release.
